// File: rtl/star_vector_accumulator_pkg.sv
// Shared STAR datapath types: element/vector types, accumulator FSM states.
// Sizing comes from `MAX_EMBEDDING_DIM, `EXPMUL_VEC_I and `EXPMUL_VEC_F.
`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 4
`endif
`ifndef EXPMUL_VEC_I
`define EXPMUL_VEC_I 8
`endif
`ifndef EXPMUL_VEC_F
`define EXPMUL_VEC_F 8
`endif

package star_vector_accumulator_pkg;

    localparam int VEC_LEN    = `MAX_EMBEDDING_DIM;
    localparam int DATA_WIDTH = `EXPMUL_VEC_I + `EXPMUL_VEC_F;

    typedef logic signed [DATA_WIDTH-1:0] star_elem_t;

    // Element 0 carries p (or l after accumulation), 1..VEC_LEN the p*V terms.
    typedef star_elem_t [VEC_LEN:0] STAR_VECTOR_T;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } STAR_ACC_STATE_T;

endpackage

// File: rtl/star_vector_accumulator_if.sv
// Row-in / vector-out handshake bundle of the STAR vector accumulator.
// The accumulator uses the slave view; its environment uses the master view.
interface star_vector_accumulator_if;
    import star_vector_accumulator_pkg::*;

    logic         vld_in;
    logic         rdy_out;
    logic         last_in;
    STAR_VECTOR_T vec_in;
    logic         vld_out;
    logic         rdy_in;
    STAR_VECTOR_T vec_out;

    modport master (
        output vld_in, last_in, vec_in, rdy_in,
        input  rdy_out, vld_out, vec_out
    );

    modport slave (
        input  vld_in, last_in, vec_in, rdy_in,
        output rdy_out, vld_out, vec_out
    );

endinterface

// File: rtl/star_vector_accumulator_elem_adder.sv
// star_elem_adder: one accumulator lane, load-or-add on enable.
// With STAR_ACC_SATURATE_EN the add clamps and reports the clamp on sat_hit.
module star_elem_adder #(
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     load,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] acc_out
`ifdef STAR_ACC_SATURATE_EN
    ,
    output logic                     sat_hit
`endif
);

    logic signed [DATA_W-1:0] acc_p1;
    logic signed [DATA_W:0]   sum_p0;
    logic signed [DATA_W-1:0] nxt_p0;

`ifdef STAR_ACC_SATURATE_EN
    function automatic logic sum_ovf(input logic signed [DATA_W:0] s);
        return s[DATA_W] ^ s[DATA_W-1];
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_clip(input logic signed [DATA_W:0] s);
        if (sum_ovf(s))
            return s[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        return s[DATA_W-1:0];
    endfunction
`endif

    // Stage p0: one guard bit makes the overflow test a sign-bit compare
    assign sum_p0 = {acc_p1[DATA_W-1], acc_p1} + {din[DATA_W-1], din};

`ifdef STAR_ACC_SATURATE_EN
    assign nxt_p0  = sat_clip(sum_p0);
    assign sat_hit = en & ~load & sum_ovf(sum_p0);
`else
    assign nxt_p0  = sum_p0[DATA_W-1:0];
`endif

    // Stage p1: accumulator register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc_p1 <= '0;
        else if (en)
            acc_p1 <= load ? din : nxt_p0;
    end

    assign acc_out = acc_p1;

endmodule

// File: rtl/star_vector_accumulator.sv
// STAR vector accumulator: sums weighted rows of a tile and hands the total downstream.
// Optional STAR_ACC_SATURATE_EN: saturating adds plus sticky sat_flag_out.
module star_vector_accumulator
    import star_vector_accumulator_pkg::*;
#(
    parameter  int MAX_KEYS = 64,
    localparam int CNT_W    = $clog2(MAX_KEYS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    star_vector_accumulator_if.slave bus,
    output logic [CNT_W-1:0]         key_cnt_out
`ifdef STAR_ACC_SATURATE_EN
    ,
    output logic                     sat_flag_out
`endif
);

    STAR_ACC_STATE_T          state_p1;
    STAR_ACC_STATE_T          state_nxt;
    logic [CNT_W-1:0]         key_cnt_p1;
    logic                     rdy;
    logic                     vld;
    logic                     accept;
    logic                     load;
    logic                     tile_end;
    logic                     handshake;
    logic signed [DATA_WIDTH-1:0] acc_p1 [0:VEC_LEN];

    assign accept    = bus.vld_in & rdy;
    assign load      = (key_cnt_p1 == '0);
    // A full tile ends regardless of last_in
    assign tile_end  = accept & (bus.last_in | (key_cnt_p1 == CNT_W'(MAX_KEYS - 1)));
    assign handshake = vld & bus.rdy_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_p1 <= ACCUM;
        else
            state_p1 <= state_nxt;
    end

    always_comb begin
        state_nxt = state_p1;
        case (state_p1)
            ACCUM:   if (tile_end)   state_nxt = EMIT;
            EMIT:    if (bus.rdy_in) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
    end

    always_comb begin
        rdy = 1'b1;
        vld = 1'b0;
        case (state_p1)
            ACCUM:   begin rdy = 1'b1; vld = 1'b0; end
            EMIT:    begin rdy = 1'b0; vld = 1'b1; end
            default: begin rdy = 1'b1; vld = 1'b0; end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            key_cnt_p1 <= '0;
        else if (handshake)
            key_cnt_p1 <= '0;
        else if (accept)
            key_cnt_p1 <= key_cnt_p1 + CNT_W'(1);
    end

`ifdef STAR_ACC_SATURATE_EN
    logic sat_hit [0:VEC_LEN];
    logic sat_any;
    logic sat_flag_p1;

    always_comb begin
        sat_any = 1'b0;
        for (int i = 0; i <= VEC_LEN; i++)
            sat_any = sat_any | sat_hit[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sat_flag_p1 <= 1'b0;
        else if (handshake)
            sat_flag_p1 <= 1'b0;
        else if (sat_any)
            sat_flag_p1 <= 1'b1;
    end

    assign sat_flag_out = sat_flag_p1;
`endif

    // Stage p1: lane registers; the first beat of a tile loads instead of adding
    for (genvar g = 0; g <= VEC_LEN; g++) begin : g_lane
        star_elem_adder #(
            .DATA_W (DATA_WIDTH)
        ) u_add (
            .clk     (clk),
            .rst     (rst),
            .en      (accept),
            .load    (load),
            .din     (bus.vec_in[g]),
            .acc_out (acc_p1[g])
`ifdef STAR_ACC_SATURATE_EN
            ,
            .sat_hit (sat_hit[g])
`endif
        );
    end

    always_comb begin
        bus.vec_out = '0;
        for (int i = 0; i <= VEC_LEN; i++)
            bus.vec_out[i] = acc_p1[i];
    end

    assign bus.rdy_out  = rdy;
    assign bus.vld_out  = vld;
    assign key_cnt_out  = key_cnt_p1;

endmodule

// File: tb/tb_star_vector_accumulator.sv
// Directed bench for star_vector_accumulator (MAX_KEYS=4); table of tiles plus hand sequences.
// Expectations for the 30000+30000 tile follow STAR_ACC_SATURATE_EN.
module tb_star_vector_accumulator;
    import star_vector_accumulator_pkg::*;

    localparam int MAX_KEYS = 4;
    localparam int CNT_W    = $clog2(MAX_KEYS + 1);

`ifdef STAR_ACC_SATURATE_EN
    localparam int BIG_SUM = 32767;
    localparam bit BIG_SAT = 1'b1;
`else
    localparam int BIG_SUM = -5536;
    localparam bit BIG_SAT = 1'b0;
`endif

    typedef struct {
        int nrows;
        bit use_last;
        int p [4];
        int v [4];
        int exp0;
        int exp1;
        int exp_cnt;
        bit exp_sat;
    } tile_t;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] key_cnt_out;
    int               checks;
    int               errors;
    tile_t            tiles [6];

    star_vector_accumulator_if bus ();

`ifdef STAR_ACC_SATURATE_EN
    logic sat_flag_out;
    star_vector_accumulator #(.MAX_KEYS(MAX_KEYS)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .key_cnt_out  (key_cnt_out),
        .sat_flag_out (sat_flag_out)
    );
`else
    star_vector_accumulator #(.MAX_KEYS(MAX_KEYS)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .key_cnt_out (key_cnt_out)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input int e0, input int e1);
        chk({name, "_l"}, longint'($signed(bus.vec_out[0])), e0);
        for (int i = 1; i <= VEC_LEN; i++)
            chk($sformatf("%s_n%0d", name, i), longint'($signed(bus.vec_out[i])), e1);
    endtask

    task automatic drive_row(input int p, input int v, input bit last);
        bus.vld_in    = 1'b1;
        bus.last_in   = last;
        bus.vec_in[0] = star_elem_t'(p);
        for (int i = 1; i <= VEC_LEN; i++)
            bus.vec_in[i] = star_elem_t'(v);
    endtask

    task automatic idle_inputs();
        bus.vld_in  = 1'b0;
        bus.last_in = 1'b0;
        bus.vec_in  = '0;
    endtask

    // Streams one tile with rdy_in high, then checks the emitted vector and the single bubble.
    task automatic run_tile(input tile_t t, input string name);
        for (int r = 0; r < t.nrows; r++) begin
            @(negedge clk);
            chk($sformatf("%s_rdy_r%0d", name, r), bus.rdy_out, 1);
            drive_row(t.p[r], t.v[r], t.use_last && (r == t.nrows - 1));
        end
        @(negedge clk);
        idle_inputs();
        chk({name, "_vld"}, bus.vld_out, 1);
        chk({name, "_bubble"}, bus.rdy_out, 0);
        chk({name, "_cnt"}, key_cnt_out, t.exp_cnt);
        chk_vec(name, t.exp0, t.exp1);
`ifdef STAR_ACC_SATURATE_EN
        chk({name, "_sat"}, sat_flag_out, t.exp_sat);
`endif
        @(negedge clk);
        chk({name, "_vld_done"}, bus.vld_out, 0);
        chk({name, "_rdy_back"}, bus.rdy_out, 1);
        chk({name, "_cnt_clr"}, key_cnt_out, 0);
`ifdef STAR_ACC_SATURATE_EN
        chk({name, "_sat_clr"}, sat_flag_out, 0);
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        bus.rdy_in = 1'b1;
        idle_inputs();

        tiles[0] = '{3, 1'b1, '{1, 3, 5, 0},             '{2, 4, 6, 0},            9,       12,      3, 1'b0};
        tiles[1] = '{4, 1'b0, '{1, 1, 1, 1},             '{1, 1, 1, 1},            4,       4,       4, 1'b0};
        tiles[2] = '{2, 1'b1, '{1, 1, 0, 0},             '{1, 1, 0, 0},            2,       2,       2, 1'b0};
        tiles[3] = '{1, 1'b1, '{7, 0, 0, 0},             '{7, 0, 0, 0},            7,       7,       1, 1'b0};
        tiles[4] = '{2, 1'b1, '{30000, 30000, 0, 0},     '{30000, 30000, 0, 0},    BIG_SUM, BIG_SUM, 2, BIG_SAT};
        tiles[5] = '{2, 1'b1, '{-3, -5, 0, 0},           '{-100, 50, 0, 0},        -8,      -50,     2, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset_vld", bus.vld_out, 0);
        chk("reset_rdy", bus.rdy_out, 1);
        chk("reset_cnt", key_cnt_out, 0);
        chk_vec("reset_vec", 0, 0);
`ifdef STAR_ACC_SATURATE_EN
        chk("reset_sat", sat_flag_out, 0);
`endif
        rst = 1'b1;

        for (int k = 0; k < 6; k++)
            run_tile(tiles[k], $sformatf("tile%0d", k));

        // Single-row tile held for 10 cycles while the next row waits upstream
        @(negedge clk);
        bus.rdy_in = 1'b0;
        drive_row(4, 11, 1'b1);
        @(negedge clk);
        drive_row(100, 100, 1'b1);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("hold_vld_%0d", k), bus.vld_out, 1);
            chk($sformatf("hold_rdy_%0d", k), bus.rdy_out, 0);
            chk($sformatf("hold_l_%0d", k), longint'($signed(bus.vec_out[0])), 4);
            chk($sformatf("hold_n_%0d", k), longint'($signed(bus.vec_out[VEC_LEN])), 11);
            chk($sformatf("hold_cnt_%0d", k), key_cnt_out, 1);
            @(negedge clk);
        end
        bus.rdy_in = 1'b1;
        @(negedge clk);
        chk("hold_release_vld", bus.vld_out, 0);
        chk("hold_release_rdy", bus.rdy_out, 1);
        @(negedge clk);
        idle_inputs();
        chk("held_row_vld", bus.vld_out, 1);
        chk("held_row_cnt", key_cnt_out, 1);
        chk_vec("held_row", 100, 100);
        @(negedge clk);
        chk("held_row_done", bus.vld_out, 0);

        // Reset mid-tile discards the partial sum immediately
        @(negedge clk);
        drive_row(1, 1, 1'b0);
        @(negedge clk);
        drive_row(1, 1, 1'b0);
        @(negedge clk);
        idle_inputs();
        chk("partial_cnt", key_cnt_out, 2);
        rst = 1'b0;
        #1;
        chk("midrst_cnt", key_cnt_out, 0);
        chk("midrst_vld", bus.vld_out, 0);
        chk("midrst_rdy", bus.rdy_out, 1);
        chk_vec("midrst_vec", 0, 0);
        @(negedge clk);
        rst = 1'b1;
        run_tile('{1, 1'b1, '{5, 0, 0, 0}, '{-9, 0, 0, 0}, 5, -9, 1, 1'b0}, "after_rst");

        // Reset while a vector is held for emission
        @(negedge clk);
        bus.rdy_in = 1'b0;
        drive_row(3, 3, 1'b1);
        @(negedge clk);
        idle_inputs();
        chk("emit_before_rst", bus.vld_out, 1);
        rst = 1'b0;
        #1;
        chk("emitrst_vld", bus.vld_out, 0);
        chk("emitrst_rdy", bus.rdy_out, 1);
        chk("emitrst_cnt", key_cnt_out, 0);
        chk_vec("emitrst_vec", 0, 0);
        @(negedge clk);
        rst = 1'b1;
        bus.rdy_in = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
